dmem_arbiter: RTL and testbench

Two-port access controller for the word-organised data memory. Shares one `dmem` instance between the core's load/store path and a debug/loader port, using round-robin arbitration. Adds byte-enable stores by sequencing a read-modify-write, since the memory only writes whole words. Sits between the requesters and `dmem`, driving its `mem_read`, `mem_write`, `addr` and `wdata` and consuming its combinational `rdata`.

---
 rtl/dmem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port controller for dmem with byte-enable read-modify-write
module dmem_arbiter #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_be,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    output logic        c_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;     // 0 = core, 1 = debug
    logic        own_q, own_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] merged_q, merged_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        win;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_be;
    logic        sel_err;

    always_comb begin
        win       = (c_req && d_req) ? prio_q : d_req;
        sel_we    = win ? d_we    : c_we;
        sel_addr  = win ? d_addr  : c_addr;
        sel_wdata = win ? d_wdata : c_wdata;
        sel_be    = win ? d_be    : c_be;
        sel_err   = (sel_addr[1:0] != 2'b00) ||
                    ({2'b00, sel_addr[31:2]} >= 32'(DEPTH_WORDS));
    end

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        own_d     = own_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        merged_d  = merged_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        c_gnt     = 1'b0;
        d_gnt     = 1'b0;
        c_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        c_rdata   = 32'h0;
        d_rdata   = 32'h0;
        c_err     = 1'b0;
        d_err     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;

        unique case (state_q)
            IDLE: begin
                if (c_req || d_req) begin
                    c_gnt    = !win;
                    d_gnt    = win;
                    own_d    = win;
                    prio_d   = !win;
                    we_d     = sel_we;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    be_d     = sel_be;
                    merged_d = sel_wdata;
                    rdata_d  = 32'h0;
                    err_d    = sel_err;
                    if (sel_err)
                        state_d = RESP;
                    else if (!sel_we)
                        state_d = ACCESS;
                    else if (sel_be == 4'hF)
                        state_d = WRITE;
                    else if (sel_be == 4'h0)
                        state_d = RESP;
                    else
                        state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_read = 1'b1;
                mem_addr = addr_q;
                if (!we_q) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end else begin
                    // Merge relies on mem_rdata being combinational this cycle.
                    for (int i = 0; i < 4; i++)
                        merged_d[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_rdata[8*i +: 8];
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = merged_q;
                state_d   = RESP;
            end
            RESP: begin
                if (own_q) begin
                    d_rvalid = 1'b1;
                    d_rdata  = we_q ? 32'h0 : rdata_q;
                    d_err    = err_q;
                end else begin
                    c_rvalid = 1'b1;
                    c_rdata  = we_q ? 32'h0 : rdata_q;
                    c_err    = err_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            own_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            be_q     <= 4'h0;
            merged_q <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            own_q    <= own_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            merged_q <= merged_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a behavioural dmem
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0;
    logic [31:0] c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0;
    logic [3:0]  c_be = 0, d_be = 0;
    logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
    logic [31:0] c_rdata, d_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int rv_cnt = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH_WORDS(1024)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_idx] <= pre_data;
        else if (mem_write)
            mem[mem_addr[11:2]] <= mem_wdata;
    end

    always @(negedge clk)
        if (c_rvalid || d_rvalid) rv_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic access(input string tag, input bit dbg, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int exp_lat,
                          input logic [31:0] exp_rd, input bit exp_err,
                          input int exp_rd_cyc, input int exp_wr_cyc);
        int lat, rd_cyc, wr_cyc;
        logic [31:0] rd;
        logic er;
        @(posedge clk); #1;
        if (dbg) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be; end
        else     begin c_req = 1; c_we = we; c_addr = addr; c_wdata = wdata; c_be = be; end
        @(negedge clk);
        check({tag, "_gnt"}, {31'b0, dbg ? d_gnt : c_gnt}, 32'd1);
        @(posedge clk); #1;
        c_req = 0; d_req = 0;
        lat = 0; rd_cyc = 0; wr_cyc = 0; rd = '0; er = 1'b0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clk);
            if (mem_read)  rd_cyc = k;
            if (mem_write) wr_cyc = k;
            if (dbg ? d_rvalid : c_rvalid) begin
                lat = k;
                rd  = dbg ? d_rdata : c_rdata;
                er  = dbg ? d_err : c_err;
            end
        end
        check({tag, "_lat"},    lat,    exp_lat);
        check({tag, "_rdata"},  rd,     exp_rd);
        check({tag, "_err"},    {31'b0, er}, {31'b0, exp_err});
        check({tag, "_rd_cyc"}, rd_cyc, exp_rd_cyc);
        check({tag, "_wr_cyc"}, wr_cyc, exp_wr_cyc);
    endtask

    initial begin
        int g_seq[$];
        int both;
        int rv_snap;

        preload(10'd4,  32'hDEADBEEF);
        preload(10'd5,  32'h01020304);
        preload(10'd8,  32'h11223344);
        preload(10'd12, 32'h55555555);
        preload(10'd16, 32'h00000000);

        @(negedge clk);
        check("rst_outputs", {c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err, mem_read, mem_write},
              32'h0);
        check("rst_memaddr", mem_addr | mem_wdata | c_rdata | d_rdata, 32'h0);
        rst = 1'b0;

        // Both ports hold load requests; grants must alternate starting with core.
        @(posedge clk); #1;
        c_req = 1; c_we = 0; c_addr = 32'h10; c_be = 4'hF;
        d_req = 1; d_we = 0; d_addr = 32'h14; d_be = 4'hF;
        both = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (c_gnt && d_gnt) both++;
            else if (c_gnt) g_seq.push_back(0);
            else if (d_gnt) g_seq.push_back(1);
        end
        @(posedge clk); #1;
        c_req = 0; d_req = 0;
        repeat (4) @(posedge clk);
        check("rr_both", both, 0);
        check("rr_count", g_seq.size(), 5);
        for (int k = 0; k < 4; k++)
            check($sformatf("rr_seq%0d", k), (k < g_seq.size()) ? g_seq[k] : -1, k % 2);

        access("c_load10", 0, 0, 32'h10, 32'h0, 4'hF, 2, 32'hDEADBEEF, 0, 1, 0);
        access("d_rmw20",  1, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 3, 32'h0, 0, 1, 2);
        access("c_rd20",   0, 0, 32'h20, 32'h0, 4'hF, 2, 32'h11BB33DD, 0, 1, 0);
        access("c_mis13",  0, 0, 32'h13, 32'h0, 4'hF, 1, 32'h0, 1, 0, 0);
        access("c_oor",    0, 0, 32'h1000, 32'h0, 4'hF, 1, 32'h0, 1, 0, 0);
        access("c_full40", 0, 1, 32'h40, 32'hCAFEF00D, 4'hF, 2, 32'h0, 0, 0, 1);
        access("c_rd40",   0, 0, 32'h40, 32'h0, 4'hF, 2, 32'hCAFEF00D, 0, 1, 0);
        access("c_be0",    0, 1, 32'h40, 32'h12345678, 4'h0, 1, 32'h0, 0, 0, 0);
        check("be0_mem", mem[16], 32'hCAFEF00D);
        access("d_load14", 1, 0, 32'h14, 32'h0, 4'hF, 2, 32'h01020304, 0, 1, 0);

        // Reset lands in the WRITE cycle of a core RMW to 0x30.
        @(posedge clk); #1;
        c_req = 1; c_we = 1; c_addr = 32'h30; c_wdata = 32'hAAAAAAAA; c_be = 4'b0011;
        @(negedge clk);
        check("rmw30_gnt", {31'b0, c_gnt}, 32'd1);
        @(posedge clk); #1;
        c_req = 0;
        @(negedge clk);
        check("rmw30_read", {31'b0, mem_read}, 32'd1);
        @(negedge clk);
        check("rmw30_write", {31'b0, mem_write}, 32'd1);
        rv_snap = rv_cnt;
        rst = 1'b1;
        #1;
        check("abort_outputs", {c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err, mem_read, mem_write},
              32'h0);
        check("abort_memaddr", mem_addr | mem_wdata | c_rdata | d_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_mem30", mem[12], 32'h55555555);
        check("abort_no_rvalid", rv_cnt, rv_snap);

        @(posedge clk); #1;
        c_req = 1; c_we = 0; c_addr = 32'h10; c_be = 4'hF;
        d_req = 1; d_we = 0; d_addr = 32'h14; d_be = 4'hF;
        @(negedge clk);
        check("post_rst_gnt", {30'b0, c_gnt, d_gnt}, 32'b10);
        @(posedge clk); #1;
        c_req = 0; d_req = 0;
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
